uart_hex_sender: RTL
====================

// Module: uart_hex_sender
// PURPOSE
//  Transmit-side companion to the UART loopback/display path: takes a 4*DIGITS-bit word
//  on a start pulse and writes it into the UART TX FIFO as ASCII hex, MS nibble first,
//  optionally followed by CR LF. Drives the uart block's wr_uart/w_data, honours tx_full.
//  Sits between the user logic (e.g. the 16-bit display word) and the uart TX FIFO.
// PARAMETERS
//  DIGITS     4  number of hex characters sent; data width = 4*DIGITS
//  ADD_CRLF   1  1: append 0x0D, 0x0A after the hex chars; 0: hex chars only
//  UPPERCASE  1  1: digits A-F as 0x41-0x46; 0: as 0x61-0x66
// PORTS
//  clk      in   1         system clock, all logic on rising edge
//  reset    in   1         synchronous, active-low reset
//  start    in   1         1-cycle request; sampled only in IDLE
//  data     in   4*DIGITS  word to send; latched on accepted start
//  tx_full  in   1         UART TX FIFO full flag
//  wr_uart  out  1         FIFO write strobe, one byte per asserted cycle
//  w_data   out  8         ASCII byte written when wr_uart=1
//  busy     out  1         1 from cycle after accepted start until last byte written
//  done     out  1         1-cycle pulse after final byte written
// BEHAVIOUR
//  - Reset (reset=0 at clk edge): state=IDLE, busy=0, done=0, wr_uart=0, char count=0,
//    shadow reg=0. Reset mid-frame aborts: remaining bytes never written.
//  - States: IDLE -> HEX -> (CR -> LF if ADD_CRLF) -> DONE -> IDLE.
//  - IDLE: start=1 latches data into shadow reg, clears char count, goes to HEX.
//    start while not IDLE (incl. DONE) is ignored; data changes after latch ignored.
//  - HEX: current nibble = shadow[4*DIGITS-1 -: 4]. w_data = nibble<10 ? 0x30+n :
//    (UPPERCASE ? 0x37+n : 0x57+n). wr_uart = ~tx_full (combinational from state).
//    On a cycle with wr_uart=1: shift shadow left 4, count+1; after DIGITS-th write go to
//    CR (ADD_CRLF=1) or DONE. tx_full=1: hold state/count, wr_uart=0, w_data stable.
//  - CR: w_data=0x0D, wr_uart=~tx_full, advance to LF on write. LF: 0x0A, advance to DONE.
//  - DONE: one cycle; done=1, busy=0, wr_uart=0; then IDLE.
//  - busy=1 in HEX/CR/LF only. wr_uart never 1 in IDLE/DONE or when tx_full=1.
//  - Latency (no backpressure, DIGITS=4, ADD_CRLF=1): start in cycle 0 -> bytes written
//    cycles 1..6, done cycle 7, start accepted again from cycle 8. Each stalled cycle
//    (tx_full=1 during HEX/CR/LF) adds exactly one cycle.
//  - w_data is don't-care when wr_uart=0 except during a stall, where it holds the
//    pending byte. Count width = clog2(DIGITS+1); no wrap beyond DIGITS.
// TESTING
//  1 data=0x1A2F, start pulse cycle 0, tx_full=0 -> wr_uart cycles 1-6 with
//    0x31,0x41,0x32,0x46,0x0D,0x0A; done=1 only in cycle 7; busy=1 cycles 1-6.
//  2 as 1, tx_full=1 cycles 2-4 -> 0x41 written in cycle 5, no write cycles 2-4,
//    w_data=0x41 throughout stall, done in cycle 10; byte order unchanged.
//  3 as 1, second start with data=0xFFFF in cycle 3 and in DONE cycle -> ignored;
//    output stream identical to test 1, no second frame.
//  4 reset=0 in cycle 3 of a frame -> wr_uart=0, busy=0, done=0 from cycle 4; no done
//    pulse; new start afterwards sends full fresh frame.
//  5 UPPERCASE=0, data=0xBEEF -> 0x62,0x65,0x65,0x66,0x0D,0x0A; data=0x0900 -> 0x30,
//    0x39,0x30,0x30 (boundary nibbles 0/9).
//  6 ADD_CRLF=0, DIGITS=2, data=0xC3 -> 0x43,0x33 in cycles 1-2, done cycle 3.

Source files
------------

// File: rtl/uart_hex_sender.sv
// uart_hex_sender: sends a 4*DIGITS-bit word to the UART TX FIFO as ASCII hex,
// most significant nibble first, optionally followed by CR LF.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-low reset
//   start    in   1-cycle request, only honoured in IDLE
//   data     in   word to send, captured when start is accepted
//   tx_full  in   UART TX FIFO full flag
//   wr_uart  out  FIFO write strobe, one byte per asserted cycle
//   w_data   out  byte written when wr_uart=1 (held during a stall)
//   busy     out  high while bytes are still to be written
//   done     out  1-cycle pulse after the final byte
//
// state  | meaning
// IDLE   | waiting for start
// HEX    | writing hex characters, one nibble per write
// CR     | writing 0x0D
// LF     | writing 0x0A
// DONE   | one-cycle completion pulse
module uart_hex_sender #(
  parameter int DIGITS    = 4,
  parameter bit ADD_CRLF  = 1'b1,
  parameter bit UPPERCASE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  tx_full,
  output logic                  wr_uart,
  output logic [7:0]            w_data,
  output logic                  busy,
  output logic                  done
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEX,
    S_CR,
    S_LF,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic [CW-1:0]   count_q, count_d;

  logic [3:0]      nibble;
  logic [7:0]      nibble8;
  logic [7:0]      hex_char;

  assign nibble  = shadow_q[DW-1 -: 4];
  assign nibble8 = {4'h0, nibble};

  always_comb begin
    if (nibble < 4'd10) begin
      hex_char = 8'h30 + nibble8;
    end else if (UPPERCASE) begin
      hex_char = 8'h37 + nibble8;
    end else begin
      hex_char = 8'h57 + nibble8;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    wr_uart  = 1'b0;
    w_data   = 8'h00;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shadow_d = data;
          count_d  = '0;
          state_d  = S_HEX;
        end
      end

      S_HEX: begin
        busy    = 1'b1;
        w_data  = hex_char;
        wr_uart = ~tx_full;
        if (!tx_full) begin
          shadow_d = shadow_q << 4;
          count_d  = count_q + CW'(1);
          if (count_q == CW'(DIGITS - 1)) begin
            state_d = ADD_CRLF ? S_CR : S_DONE;
          end
        end
      end

      S_CR: begin
        busy    = 1'b1;
        w_data  = 8'h0D;
        wr_uart = ~tx_full;
        if (!tx_full) begin
          state_d = S_LF;
        end
      end

      S_LF: begin
        busy    = 1'b1;
        w_data  = 8'h0A;
        wr_uart = ~tx_full;
        if (!tx_full) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
